// File: rtl/g729_pkg.sv
// Shared constants and types for the G.729 filter datapath blocks.
package g729_pkg;

  localparam int unsigned M       = 10;
  localparam int unsigned L_SUBFR = 40;

  localparam int unsigned AW    = 11;
  localparam int unsigned DW    = 16;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned TAP_W = 4;
  localparam int unsigned SMP_W = 6;

  localparam logic [ACC_W-1:0] MAX_32  = 32'h7FFF_FFFF;
  localparam logic [ACC_W-1:0] MIN_32  = 32'h8000_0000;
  localparam logic [ACC_W-1:0] ROUND_K = 32'h0000_8000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_MAC,
    S_WRITE,
    S_DONE
  } residu_state_t;

endpackage

// File: rtl/residu_filt_if.sv
// Start/address and scratch-memory bus of the residual filter.
// Optional `overflow` signal is present when RESIDU_OVERFLOW_EN is defined.
interface residu_filt_if;
  import g729_pkg::*;

  logic          start;
  logic [AW-1:0] xAddr;
  logic [AW-1:0] aAddr;
  logic [AW-1:0] yAddr;
  logic [AW-1:0] memReadAddr;
  logic [31:0]   memIn;
  logic          memWriteEn;
  logic [AW-1:0] memWriteAddr;
  logic [31:0]   memOut;
  logic          done;
`ifdef RESIDU_OVERFLOW_EN
  logic          overflow;
`endif

  modport master (
    output start, xAddr, aAddr, yAddr, memIn,
    input  memReadAddr, memWriteEn, memWriteAddr, memOut, done
`ifdef RESIDU_OVERFLOW_EN
    , input overflow
`endif
  );

  modport slave (
    input  start, xAddr, aAddr, yAddr, memIn,
    output memReadAddr, memWriteEn, memWriteAddr, memOut, done
`ifdef RESIDU_OVERFLOW_EN
    , output overflow
`endif
  );

endinterface

// File: rtl/residu_mac.sv
// Combinational saturating L_mult/L_mac step plus L_shl(3) and rounding of the result.
module residu_mac
  import g729_pkg::*;
(
  input  logic [ACC_W-1:0] i_acc,
  input  logic [DW-1:0]    i_a,
  input  logic [DW-1:0]    i_x,
  input  logic             i_first,
  input  logic             i_last,
  output logic [ACC_W-1:0] o_acc_c,
  output logic [DW-1:0]    o_y_c,
  output logic             o_sat_c
);

  logic signed [30:0] w_prod;
  logic [ACC_W-1:0]   w_mult;
  logic               w_mult_sat;
  logic [ACC_W-1:0]   w_base;
  logic [ACC_W:0]     w_sum;
  logic [ACC_W-1:0]   w_mac;
  logic               w_mac_sat;
  logic               w_shl_sat;
  logic [ACC_W-1:0]   w_shl;
  logic [ACC_W:0]     w_rsum;
  logic               w_rnd_sat;
  logic               w_unused;

  // Multiply-accumulate, shift and round with ITU saturation at every stage
  always_comb begin
    // Only -32768 * -32768 exceeds 31 bits; that case is overridden below
    w_prod     = 31'($signed(i_a)) * 31'($signed(i_x));
    w_mult_sat = (i_a == 16'h8000) && (i_x == 16'h8000);
    w_mult     = w_mult_sat ? MAX_32 : {w_prod, 1'b0};

    w_base    = i_first ? '0 : i_acc;
    w_sum     = {w_base[ACC_W-1], w_base} + {w_mult[ACC_W-1], w_mult};
    w_mac_sat = w_sum[ACC_W] != w_sum[ACC_W-1];
    w_mac     = w_mac_sat ? (w_sum[ACC_W] ? MIN_32 : MAX_32) : w_sum[ACC_W-1:0];

    // Shift by 3 is exact only when the top four bits agree
    w_shl_sat = (w_mac[31:28] != 4'b0000) && (w_mac[31:28] != 4'b1111);
    w_shl     = w_shl_sat ? (w_mac[31] ? MIN_32 : MAX_32) : {w_mac[28:0], 3'b000};

    // Adding a positive constant can only overflow upward
    w_rsum    = {w_shl[ACC_W-1], w_shl} + {1'b0, ROUND_K};
    w_rnd_sat = w_rsum[ACC_W] != w_rsum[ACC_W-1];

    o_acc_c = w_mac;
    o_y_c   = w_rnd_sat ? 16'h7FFF : w_rsum[31:16];
    o_sat_c = w_mult_sat | w_mac_sat | (i_last & (w_shl_sat | w_rnd_sat));
  end

  assign w_unused = ^w_rsum[15:0];

endmodule

// File: rtl/residu_filt.sv
// Order-10 LPC residual (analysis) filter over a shared scratch memory.
// Define RESIDU_OVERFLOW_EN to add the sticky `overflow` output.
module residu_filt
  import g729_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  residu_filt_if.slave bus
);

  residu_state_t    r_state, w_state_nxt;
  logic [TAP_W-1:0] r_j, w_j_nxt, w_tap;
  logic [SMP_W-1:0] r_n, w_n_nxt;
  logic [AW-1:0]    r_xaddr, w_xaddr_nxt;
  logic [AW-1:0]    r_aaddr, w_aaddr_nxt;
  logic [AW-1:0]    r_yaddr, w_yaddr_nxt;
  logic [AW-1:0]    r_rd_addr, w_rd_addr_nxt;
  logic [AW-1:0]    r_wr_addr, w_wr_addr_nxt;
  logic [ACC_W-1:0] r_wr_data, w_wr_data_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic             r_we, w_we_nxt;
  logic             r_done, w_done_nxt;
  logic [DW-1:0]    r_coef [0:M];
  logic             w_coef_we;
  logic             w_mac_en;
  logic             w_ovf_clr;
  logic [ACC_W-1:0] w_mac_acc;
  logic [DW-1:0]    w_mac_y;
  logic             w_mac_sat;
  logic             w_unused;

  // Data returned this cycle belongs to the tap issued one cycle earlier
  assign w_tap = r_j - TAP_W'(1);

  residu_mac u_mac (
    .i_acc   (r_acc),
    .i_a     (r_coef[w_tap]),
    .i_x     (bus.memIn[DW-1:0]),
    .i_first (r_j == TAP_W'(1)),
    .i_last  (r_j == TAP_W'(M + 1)),
    .o_acc_c (w_mac_acc),
    .o_y_c   (w_mac_y),
    .o_sat_c (w_mac_sat)
  );

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_j_nxt       = r_j;
    w_n_nxt       = r_n;
    w_xaddr_nxt   = r_xaddr;
    w_aaddr_nxt   = r_aaddr;
    w_yaddr_nxt   = r_yaddr;
    w_rd_addr_nxt = r_rd_addr;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_acc_nxt     = r_acc;
    w_we_nxt      = 1'b0;
    w_done_nxt    = 1'b0;
    w_coef_we     = 1'b0;
    w_mac_en      = 1'b0;
    w_ovf_clr     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt   = S_LOAD_A;
          w_j_nxt       = '0;
          w_n_nxt       = '0;
          w_xaddr_nxt   = bus.xAddr;
          w_aaddr_nxt   = bus.aAddr;
          w_yaddr_nxt   = bus.yAddr;
          w_rd_addr_nxt = bus.aAddr;
          w_ovf_clr     = 1'b1;
        end
      end
      S_LOAD_A: begin
        w_coef_we = (r_j != '0);
        if (r_j == TAP_W'(M + 1)) begin
          w_state_nxt   = S_MAC;
          w_j_nxt       = '0;
          w_rd_addr_nxt = r_xaddr + AW'(r_n);
        end else begin
          w_j_nxt = r_j + TAP_W'(1);
          if (r_j < TAP_W'(M)) w_rd_addr_nxt = r_aaddr + AW'(r_j) + AW'(1);
        end
      end
      S_MAC: begin
        if (r_j != '0) begin
          w_mac_en  = 1'b1;
          w_acc_nxt = w_mac_acc;
        end
        if (r_j == TAP_W'(M + 1)) begin
          w_state_nxt   = S_WRITE;
          w_we_nxt      = 1'b1;
          w_wr_addr_nxt = r_yaddr + AW'(r_n);
          w_wr_data_nxt = {{(ACC_W - DW){w_mac_y[DW-1]}}, w_mac_y};
        end else begin
          w_j_nxt = r_j + TAP_W'(1);
          if (r_j < TAP_W'(M)) w_rd_addr_nxt = r_xaddr + AW'(r_n) - AW'(r_j) - AW'(1);
        end
      end
      S_WRITE: begin
        if (r_n == SMP_W'(L_SUBFR - 1)) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt   = S_MAC;
          w_n_nxt       = r_n + SMP_W'(1);
          w_j_nxt       = '0;
          w_rd_addr_nxt = r_xaddr + AW'(r_n) + AW'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counters, accumulator and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_j       <= '0;
      r_n       <= '0;
      r_xaddr   <= '0;
      r_aaddr   <= '0;
      r_yaddr   <= '0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_acc     <= '0;
      r_we      <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_j       <= w_j_nxt;
      r_n       <= w_n_nxt;
      r_xaddr   <= w_xaddr_nxt;
      r_aaddr   <= w_aaddr_nxt;
      r_yaddr   <= w_yaddr_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_acc     <= w_acc_nxt;
      r_we      <= w_we_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Coefficient register file, loaded once per invocation
  always_ff @(posedge clk) begin
    if (w_coef_we) r_coef[w_tap] <= bus.memIn[DW-1:0];
  end

  assign bus.memReadAddr  = r_rd_addr;
  assign bus.memWriteEn   = r_we;
  assign bus.memWriteAddr = r_wr_addr;
  assign bus.memOut       = r_wr_data;
  assign bus.done         = r_done;

`ifdef RESIDU_OVERFLOW_EN
  logic r_ovf;

  // Sticky saturation flag, cleared by reset or an accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       r_ovf <= 1'b0;
    else if (w_ovf_clr)              r_ovf <= 1'b0;
    else if (w_mac_en && w_mac_sat)  r_ovf <= 1'b1;
  end

  assign bus.overflow = r_ovf;
  assign w_unused     = ^bus.memIn[31:DW];
`else
  assign w_unused = ^{bus.memIn[31:DW], w_mac_sat, w_mac_en, w_ovf_clr};
`endif

endmodule

// File: tb/tb_residu_filt.sv
// Self-checking bench for residu_filt: directed and random windows against a reference model.
module tb_residu_filt;
  import g729_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  residu_filt_if bus ();

  residu_filt dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:2047];
  int unsigned cyc = 0;
  logic [10:0] wa_q [$];
  logic [31:0] wd_q [$];
  int unsigned done_cnt = 0;
  int unsigned done_cyc = 0;

  int n_chk  = 0;
  int n_fail = 0;

  int coef [0:10];
  int xs   [0:49];   // xs[k] holds x[k-10]
  int exp_y [0:39];
  bit exp_ovf;

  always @(posedge clk) cyc <= cyc + 1;

  // Scratch memory: read data valid the cycle after the address
  always @(posedge clk) bus.memIn <= mem[bus.memReadAddr];

  // Write and done monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.memWriteEn) begin
        wa_q.push_back(bus.memWriteAddr);
        wd_q.push_back(bus.memOut);
      end
      if (bus.done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic longint clamp32(input longint v);
    if (v > 64'sd2147483647)  return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  // Reference: y[n] = round(L_shl(sum a[j]*x[n-j], 3)) with saturation at every basic op
  task automatic ref_model();
    longint s, p, t;
    exp_ovf = 1'b0;
    for (int n = 0; n < 40; n++) begin
      s = 0;
      for (int j = 0; j <= 10; j++) begin
        t = 2 * longint'(coef[j]) * longint'(xs[n - j + 10]);
        p = clamp32(t);
        if (p != t) exp_ovf = 1'b1;
        if (j == 0) s = p;
        else begin
          t = s + p;
          s = clamp32(t);
          if (s != t) exp_ovf = 1'b1;
        end
      end
      t = s * 8;
      s = clamp32(t);
      if (s != t) exp_ovf = 1'b1;
      t = s + 32768;
      s = clamp32(t);
      if (s != t) exp_ovf = 1'b1;
      exp_y[n] = int'(s >>> 16);
    end
  endtask

  task automatic load_mem(input int xa, input int aa);
    for (int j = 0; j <= 10; j++)
      mem[(aa + j) & 2047] = {16'($urandom), 16'(coef[j])};
    for (int k = 0; k < 50; k++)
      mem[(xa + k - 10) & 2047] = {16'($urandom), 16'(xs[k])};
  endtask

  task automatic pulse_start(input int xa, input int aa, input int ya, output int unsigned t0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.xAddr = 11'(xa);
    bus.aAddr = 11'(aa);
    bus.yAddr = 11'(ya);
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.start = 1'b0;
    // Later address changes must not affect the running pass
    bus.xAddr = 11'($urandom);
    bus.aAddr = 11'($urandom);
    bus.yAddr = 11'($urandom);
  endtask

  // One full invocation; extra_start > 0 pulses start again at that cycle
  task automatic run_case(input string name, input int xa, input int aa, input int ya,
                          input int extra_start);
    int unsigned t0, nw0, nd0, nw;
    load_mem(xa, aa);
    nw0 = wa_q.size();
    nd0 = done_cnt;
    pulse_start(xa, aa, ya, t0);
    for (int i = 0; i < 800; i++) begin
      tick();
      bus.start = (extra_start > 0) && (cyc - t0 + 1 == extra_start);
      if (done_cnt != nd0) break;
    end
    bus.start = 1'b0;
    tick();
    check_eq({name, "_done_width"}, 32'(bus.done), 32'd0);
    repeat (4) tick();
    check_eq({name, "_done_cnt"}, done_cnt - nd0, 32'd1);
    // Cycle 1 is the cycle that begins at the start-sampling edge
    check_eq({name, "_done_cycle"}, done_cyc - t0 + 1, 32'd533);
    nw = wa_q.size() - nw0;
    check_eq({name, "_nwrites"}, nw, 32'd40);
    for (int k = 0; k < 40 && k < int'(nw); k++) begin
      check_eq($sformatf("%s_addr%0d", name, k), 32'(wa_q[nw0 + k]), 32'((ya + k) & 2047));
      check_eq($sformatf("%s_y%0d", name, k), wd_q[nw0 + k], 32'(exp_y[k]));
    end
`ifdef RESIDU_OVERFLOW_EN
    check_eq({name, "_overflow"}, 32'(bus.overflow), 32'(exp_ovf));
`endif
  endtask

  task automatic rand_window(input int a_span, input int x_span);
    for (int j = 0; j <= 10; j++) coef[j] = int'($urandom_range(0, 2 * a_span - 1)) - a_span;
    for (int k = 0; k < 50; k++)  xs[k]   = int'($urandom_range(0, 2 * x_span - 1)) - x_span;
    ref_model();
  endtask

  task automatic check_reset_values(input string name);
    check_eq({name, "_rd_addr"}, 32'(bus.memReadAddr), 32'd0);
    check_eq({name, "_we"},      32'(bus.memWriteEn), 32'd0);
    check_eq({name, "_wr_addr"}, 32'(bus.memWriteAddr), 32'd0);
    check_eq({name, "_memout"},  bus.memOut, 32'd0);
    check_eq({name, "_done"},    32'(bus.done), 32'd0);
`ifdef RESIDU_OVERFLOW_EN
    check_eq({name, "_overflow"}, 32'(bus.overflow), 32'd0);
`endif
  endtask

  initial begin
    int unsigned t0, nw0, nd0;
    int xa, aa, ya;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.xAddr = '0;
    bus.aAddr = '0;
    bus.yAddr = '0;
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_reset_values("rst");

    // Identity: y[n] = x[n] = n
    foreach (coef[j]) coef[j] = 0;
    coef[0] = 4096;
    for (int k = 0; k < 50; k++) xs[k] = k - 10;
    for (int n = 0; n < 40; n++) exp_y[n] = n;
    exp_ovf = 1'b0;
    run_case("ident", 100, 140, 300, 0);

    // First difference of k^2 with the x window wrapping the address space
    foreach (coef[j]) coef[j] = 0;
    coef[0] = 4096;
    coef[1] = -4096;
    for (int k = 0; k < 50; k++) xs[k] = (k - 10) * (k - 10);
    for (int n = 0; n < 40; n++) exp_y[n] = 2 * n - 1;
    exp_ovf = 1'b0;
    run_case("diff", 2045, (2045 + 40) & 2047, (2045 + 60) & 2047, 0);

    // Positive saturation
    foreach (coef[j]) coef[j] = 0;
    coef[0] = 32767;
    coef[1] = 32767;
    for (int k = 0; k < 50; k++) xs[k] = 32767;
    for (int n = 0; n < 40; n++) exp_y[n] = 32767;
    exp_ovf = 1'b1;
    run_case("satpos", 500, 560, 700, 0);

    // Negative saturation
    foreach (coef[j]) coef[j] = 0;
    coef[0] = -32768;
    for (int k = 0; k < 50; k++) xs[k] = 32767;
    for (int n = 0; n < 40; n++) exp_y[n] = -32768;
    exp_ovf = 1'b1;
    run_case("satneg", 900, 960, 1100, 0);

    // Small values: no saturation, so the sticky flag must clear on start
    rand_window(512, 4096);
    run_case("small", 1200, 1250, 1300, 0);

    // A second start mid-run is ignored
    rand_window(4096, 32768);
    run_case("dblstart", 50, 95, 400, 100);

    // Reset mid-run: no writes and no done afterwards
    rand_window(4096, 32768);
    load_mem(600, 650);
    pulse_start(600, 650, 800, t0);
    for (int i = 0; i < 300 && (cyc - t0 + 1) < 200; i++) tick();
    reset = 1'b1;
    nw0 = wa_q.size();
    nd0 = done_cnt;
    tick();
    check_reset_values("midrst");
    tick();
    reset = 1'b0;
    repeat (600) tick();
    check_eq("midrst_writes_after", wa_q.size() - nw0, 32'd0);
    check_eq("midrst_done_after", done_cnt - nd0, 32'd0);

    rand_window(4096, 32768);
    run_case("afterrst", 600, 650, 800, 0);

    // Random windows and placements
    for (int r = 0; r < 3; r++) begin
      xa = int'($urandom_range(0, 2047));
      aa = (xa + 40) & 2047;
      ya = (xa + 60 + int'($urandom_range(0, 1900))) & 2047;
      if (r == 2) rand_window(32768, 32768);
      else        rand_window(2048, 32768);
      run_case($sformatf("rnd%0d", r), xa, aa, ya, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
